// File: rtl/por_seq_pkg.sv
// Shared types and helpers for the POR reset sequencer.
package por_seq_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    DEBOUNCE  = 3'd1,
    WAIT_LOCK = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } por_seq_state_t;

  // Index width for n items, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/por_sync_cell.sv
// Multi-flop synchronizer; optional async clear so a low on i_clr_n
// empties the chain without needing a clock edge.
module por_sync_cell #(
  parameter int STAGES = 2,
  parameter bit CLR_EN = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  input  logic i_clr_n,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;
  logic              w_clr;

  assign w_clr = rst | (CLR_EN & ~i_clr_n);

  // Shift chain, cleared to 0 (power not good / not locked) on clear.
  always_ff @(posedge clk or posedge w_clr) begin
    if (w_clr) r_sync <= '0;
    else       r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/por_reset_sequencer.sv
// POR consumer: synchronizes/debounces POR, waits for PLL lock, then
// releases NUM_DOM domain resets in order, GAP_CYC cycles apart.
// Optional lock watchdog enabled by defining POR_SEQ_WDOG_EN.
module por_reset_sequencer
  import por_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYC     = 64,
  parameter int NUM_DOM     = 4,
  parameter int GAP_CYC     = 16,
  parameter int LOCK_TMO    = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               por_n_i,
  input  logic               pll_lock_i,
  output logic [NUM_DOM-1:0] dom_rst_o,
  output logic               seq_done_o,
`ifdef POR_SEQ_WDOG_EN
  output logic               lock_err_o,
`endif
  output logic [2:0]         state_o
);

  localparam int               IDX_W    = clog2_min1(NUM_DOM);
  localparam logic [CNT_W-1:0] DEB_LIM  = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LIM  = CNT_W'(LOCK_TMO - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOM - 1);

  logic                w_por_s;
  logic                w_lock_s;
  logic                w_lock_loss;
  logic                w_tmo_hit;
  logic [IDX_W-1:0]    w_nxt_idx;

  por_seq_state_t      r_state;
  logic [CNT_W-1:0]    r_deb_cnt;
  logic [CNT_W-1:0]    r_gap_cnt;
  logic [IDX_W-1:0]    r_dom_idx;
  logic [NUM_DOM-1:0]  r_dom_rst;
  logic                r_seq_done;

  // POR loss clears the chain immediately, even with the clock stopped.
  por_sync_cell #(.STAGES(SYNC_STAGES), .CLR_EN(1'b1)) u_por_sync (
    .clk     (clk),
    .rst     (rst),
    .i_d     (por_n_i),
    .i_clr_n (por_n_i),
    .o_q     (w_por_s)
  );

  por_sync_cell #(.STAGES(2), .CLR_EN(1'b0)) u_lock_sync (
    .clk     (clk),
    .rst     (rst),
    .i_d     (pll_lock_i),
    .i_clr_n (1'b1),
    .o_q     (w_lock_s)
  );

  assign w_nxt_idx = r_dom_idx + IDX_W'(1);

`ifdef POR_SEQ_WDOG_EN
  logic             r_lock_err;
  logic [CNT_W-1:0] r_tmo_cnt;

  // Once the watchdog has fired we are in degraded boot; lock is untrusted.
  assign w_lock_loss = ~w_lock_s & ~r_lock_err;
  assign w_tmo_hit   = (r_tmo_cnt == TMO_LIM);
  assign lock_err_o  = r_lock_err;

  // Watchdog timer: runs only while waiting for lock, sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt  <= '0;
      r_lock_err <= 1'b0;
    end else if (!w_por_s && r_state != HOLD) begin
      r_tmo_cnt  <= '0;
      r_lock_err <= 1'b0;
    end else if (r_state != WAIT_LOCK) begin
      r_tmo_cnt  <= '0;
    end else begin
      if (w_tmo_hit && !w_lock_s) r_lock_err <= 1'b1;
      if (!w_tmo_hit)             r_tmo_cnt  <= r_tmo_cnt + 1'b1;
    end
  end
`else
  logic w_unused_tmo;

  assign w_lock_loss  = ~w_lock_s;
  assign w_tmo_hit    = 1'b0;
  assign w_unused_tmo = ^TMO_LIM;
`endif

  // Main sequencer; POR abort outranks lock loss, outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= HOLD;
      r_deb_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_dom_idx  <= '0;
      r_dom_rst  <= '1;
      r_seq_done <= 1'b0;
    end else if (!w_por_s && r_state != HOLD) begin
      r_state    <= HOLD;
      r_deb_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_dom_idx  <= '0;
      r_dom_rst  <= '1;
      r_seq_done <= 1'b0;
    end else begin
      case (r_state)
        HOLD: begin
          r_deb_cnt  <= '0;
          r_dom_rst  <= '1;
          r_seq_done <= 1'b0;
          if (w_por_s) r_state <= DEBOUNCE;
        end
        DEBOUNCE: begin
          if (r_deb_cnt == DEB_LIM) r_state   <= WAIT_LOCK;
          else                      r_deb_cnt <= r_deb_cnt + 1'b1;
        end
        WAIT_LOCK: begin
          if (w_lock_s || w_tmo_hit) begin
            r_state      <= RELEASE;
            r_dom_idx    <= '0;
            r_gap_cnt    <= '0;
            r_dom_rst[0] <= 1'b0;
          end
        end
        RELEASE: begin
          if (w_lock_loss) begin
            r_state   <= WAIT_LOCK;
            r_dom_rst <= '1;
            r_dom_idx <= '0;
            r_gap_cnt <= '0;
          end else if (r_gap_cnt == GAP_LIM) begin
            if (r_dom_idx == LAST_IDX) begin
              r_state    <= RUN;
              r_seq_done <= 1'b1;
            end else begin
              r_dom_idx            <= w_nxt_idx;
              r_gap_cnt            <= '0;
              r_dom_rst[w_nxt_idx] <= 1'b0;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        RUN: begin
          if (w_lock_loss) begin
            r_state    <= WAIT_LOCK;
            r_dom_rst  <= '1;
            r_dom_idx  <= '0;
            r_gap_cnt  <= '0;
            r_seq_done <= 1'b0;
          end
        end
        default: begin
          r_state   <= HOLD;
          r_dom_rst <= '1;
        end
      endcase
    end
  end

  assign dom_rst_o  = r_dom_rst;
  assign seq_done_o = r_seq_done;
  assign state_o    = r_state;

endmodule

// File: tb/tb_por_reset_sequencer.sv
// Directed bench for por_reset_sequencer (default parameters, LOCK_TMO=100).
module tb_por_reset_sequencer;

  logic       clk;
  logic       clk_en;
  logic       rst;
  logic       por_n_i;
  logic       pll_lock_i;
  logic [3:0] dom_rst_o;
  logic       seq_done_o;
  logic [2:0] state_o;
`ifdef POR_SEQ_WDOG_EN
  logic       lock_err_o;
`endif

  int errors = 0;
  int checks = 0;

  por_reset_sequencer #(.LOCK_TMO(100)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .por_n_i    (por_n_i),
    .pll_lock_i (pll_lock_i),
    .dom_rst_o  (dom_rst_o),
    .seq_done_o (seq_done_o),
`ifdef POR_SEQ_WDOG_EN
    .lock_err_o (lock_err_o),
`endif
    .state_o    (state_o)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
      else        clk = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    por_n_i = 1'b0;
    tick(3);
    rst     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; por_n_i = 1'b1; pll_lock_i = 1'b1;
    tick(3);
    checks++;
    if (dom_rst_o !== 4'b1111) begin errors++; $display("FAIL reset_dom got=%b exp=1111", dom_rst_o); end
    checks++;
    if (seq_done_o !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", seq_done_o); end
    checks++;
    if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_o); end
  endtask

  task automatic test_normal();
    do_reset();
    pll_lock_i = 1'b1;
    por_n_i    = 1'b1;
    tick(2);
    checks++;
    if (state_o !== 3'd0) begin errors++; $display("FAIL norm_sync_state got=%0d exp=0", state_o); end
    tick(1);
    checks++;
    if (state_o !== 3'd1) begin errors++; $display("FAIL norm_deb_state got=%0d exp=1", state_o); end
    tick(64);   // edge 67
    checks++;
    if (dom_rst_o !== 4'b1111 || state_o !== 3'd2) begin errors++; $display("FAIL norm_e67 dom=%b st=%0d exp=1111/2", dom_rst_o, state_o); end
    tick(1);    // edge 68
    checks++;
    if (dom_rst_o !== 4'b1110 || state_o !== 3'd3) begin errors++; $display("FAIL norm_e68 dom=%b st=%0d exp=1110/3", dom_rst_o, state_o); end
    tick(15);   // edge 83
    checks++;
    if (dom_rst_o !== 4'b1110) begin errors++; $display("FAIL norm_e83 dom=%b exp=1110", dom_rst_o); end
    tick(1);    // edge 84
    checks++;
    if (dom_rst_o !== 4'b1100) begin errors++; $display("FAIL norm_e84 dom=%b exp=1100", dom_rst_o); end
    tick(16);   // edge 100
    checks++;
    if (dom_rst_o !== 4'b1000) begin errors++; $display("FAIL norm_e100 dom=%b exp=1000", dom_rst_o); end
    tick(16);   // edge 116
    checks++;
    if (dom_rst_o !== 4'b0000) begin errors++; $display("FAIL norm_e116 dom=%b exp=0000", dom_rst_o); end
    tick(15);   // edge 131
    checks++;
    if (seq_done_o !== 1'b0 || state_o !== 3'd3) begin errors++; $display("FAIL norm_e131 done=%b st=%0d exp=0/3", seq_done_o, state_o); end
    tick(1);    // edge 132
    checks++;
    if (seq_done_o !== 1'b1 || state_o !== 3'd4) begin errors++; $display("FAIL norm_e132 done=%b st=%0d exp=1/4", seq_done_o, state_o); end
  endtask

  task automatic test_glitch();
    do_reset();
    pll_lock_i = 1'b1;
    por_n_i    = 1'b1;
    tick(43);   // deb_cnt = 40
    por_n_i = 1'b0;
    tick(1);
    checks++;
    if (state_o !== 3'd0) begin errors++; $display("FAIL glitch_hold got=%0d exp=0", state_o); end
    por_n_i = 1'b1;
    tick(24);   // where the unglitched release would have been
    checks++;
    if (dom_rst_o !== 4'b1111) begin errors++; $display("FAIL glitch_early dom=%b exp=1111", dom_rst_o); end
    tick(43);   // 67 after glitch end
    checks++;
    if (dom_rst_o !== 4'b1111) begin errors++; $display("FAIL glitch_e67 dom=%b exp=1111", dom_rst_o); end
    tick(1);
    checks++;
    if (dom_rst_o !== 4'b1110) begin errors++; $display("FAIL glitch_e68 dom=%b exp=1110", dom_rst_o); end
  endtask

  task automatic test_async_abort();
    do_reset();
    pll_lock_i = 1'b1;
    por_n_i    = 1'b1;
    tick(90);
    checks++;
    if (dom_rst_o !== 4'b1100) begin errors++; $display("FAIL abort_pre dom=%b exp=1100", dom_rst_o); end
    clk_en = 1'b0;
    #20;
    por_n_i = 1'b0;
    #10;
    checks++;
    if (u_dut.w_por_s !== 1'b0) begin errors++; $display("FAIL abort_sync_clr got=%b exp=0", u_dut.w_por_s); end
    checks++;
    if (dom_rst_o !== 4'b1100) begin errors++; $display("FAIL abort_noclk dom=%b exp=1100", dom_rst_o); end
    clk_en = 1'b1;
    tick(1);
    checks++;
    if (dom_rst_o !== 4'b1111 || state_o !== 3'd0) begin errors++; $display("FAIL abort_resume dom=%b st=%0d exp=1111/0", dom_rst_o, state_o); end
  endtask

  task automatic test_lock();
    bit stayed;
    do_reset();
    pll_lock_i = 1'b0;
    por_n_i    = 1'b1;
    tick(67);
    stayed = 1'b1;
    for (int i = 0; i < 500; i++) begin
      tick(1);
      if (state_o !== 3'd2 || dom_rst_o !== 4'b1111) stayed = 1'b0;
    end
    checks++;
    if (!stayed) begin errors++; $display("FAIL lock_wait got=%0d exp=2 throughout", state_o); end
    pll_lock_i = 1'b1;
    tick(2);
    checks++;
    if (state_o !== 3'd2 || dom_rst_o !== 4'b1111) begin errors++; $display("FAIL lock_rise2 st=%0d dom=%b exp=2/1111", state_o, dom_rst_o); end
    tick(1);
    checks++;
    if (state_o !== 3'd3 || dom_rst_o !== 4'b1110) begin errors++; $display("FAIL lock_rise3 st=%0d dom=%b exp=3/1110", state_o, dom_rst_o); end
    tick(64);
    checks++;
    if (seq_done_o !== 1'b1 || state_o !== 3'd4) begin errors++; $display("FAIL lock_run done=%b st=%0d exp=1/4", seq_done_o, state_o); end
    pll_lock_i = 1'b0;
    tick(2);
    checks++;
    if (state_o !== 3'd4 || seq_done_o !== 1'b1) begin errors++; $display("FAIL lock_drop2 st=%0d done=%b exp=4/1", state_o, seq_done_o); end
    tick(1);
    checks++;
    if (state_o !== 3'd2 || dom_rst_o !== 4'b1111 || seq_done_o !== 1'b0) begin errors++; $display("FAIL lock_drop3 st=%0d dom=%b done=%b exp=2/1111/0", state_o, dom_rst_o, seq_done_o); end
    pll_lock_i = 1'b1;
    tick(3);
    checks++;
    if (state_o !== 3'd3 || dom_rst_o !== 4'b1110) begin errors++; $display("FAIL lock_restart st=%0d dom=%b exp=3/1110", state_o, dom_rst_o); end
  endtask

  task automatic test_priority();
    do_reset();
    pll_lock_i = 1'b1;
    por_n_i    = 1'b1;
    tick(90);
    por_n_i    = 1'b0;
    pll_lock_i = 1'b0;
    tick(1);
    checks++;
    if (state_o !== 3'd0 || dom_rst_o !== 4'b1111) begin errors++; $display("FAIL prio_e1 st=%0d dom=%b exp=0/1111", state_o, dom_rst_o); end
    tick(5);
    checks++;
    if (state_o !== 3'd0) begin errors++; $display("FAIL prio_e6 st=%0d exp=0", state_o); end
  endtask

`ifdef POR_SEQ_WDOG_EN
  task automatic test_wdog();
    do_reset();
    pll_lock_i = 1'b0;
    por_n_i    = 1'b1;
    tick(67);
    checks++;
    if (state_o !== 3'd2) begin errors++; $display("FAIL wdog_wait st=%0d exp=2", state_o); end
    tick(99);
    checks++;
    if (lock_err_o !== 1'b0 || state_o !== 3'd2) begin errors++; $display("FAIL wdog_e99 err=%b st=%0d exp=0/2", lock_err_o, state_o); end
    tick(1);
    checks++;
    if (lock_err_o !== 1'b1 || state_o !== 3'd3 || dom_rst_o !== 4'b1110) begin errors++; $display("FAIL wdog_e100 err=%b st=%0d dom=%b exp=1/3/1110", lock_err_o, state_o, dom_rst_o); end
    tick(64);
    checks++;
    if (seq_done_o !== 1'b1 || dom_rst_o !== 4'b0000 || lock_err_o !== 1'b1) begin errors++; $display("FAIL wdog_done done=%b dom=%b err=%b exp=1/0000/1", seq_done_o, dom_rst_o, lock_err_o); end
    por_n_i = 1'b0;
    tick(1);
    checks++;
    if (lock_err_o !== 1'b0 || state_o !== 3'd0) begin errors++; $display("FAIL wdog_clr err=%b st=%0d exp=0/0", lock_err_o, state_o); end
  endtask
`endif

  initial begin
    clk_en     = 1'b1;
    rst        = 1'b1;
    por_n_i    = 1'b0;
    pll_lock_i = 1'b0;
    test_reset();
    test_normal();
    test_glitch();
    test_async_abort();
    test_lock();
    test_priority();
`ifdef POR_SEQ_WDOG_EN
    test_wdog();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
